// File: rtl/ti4_pkg.sv
// Shared definitions for the ti4 nibble machine: memory geometry and the
// instruction-fetch state encoding used by ifetch, Mem and the decoder.
package ti4_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OP_ADDR  = 3'd1,
    OP_DATA  = 3'd2,
    ARG_DATA = 3'd3,
    VALID    = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/ifetch.sv
// Two-nibble instruction fetcher: reads opcode and operand from a
// one-cycle-latency memory and offers them on a valid/ready port.
module ifetch
  import ti4_pkg::*;
#(
  parameter int ADDR_W = ti4_pkg::ADDR_W,
  parameter int DATA_W = ti4_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic [ADDR_W-1:0] instr_pc,
  output fetch_state_t      state
);

  // Handshake: instr_valid rises only in VALID and then holds, with the
  // payload stable, until a cycle where instr_ready is also high; that
  // cycle transfers the instruction unless jump_valid is high too, in
  // which case the held instruction is dropped.

  logic [ADDR_W-1:0] pc;
  logic              handshake;

  assign handshake = instr_valid && instr_ready;
  assign mem_we    = 1'b0;

  // Operand address is presented while the opcode nibble is returning.
  always_comb begin
    mem_addr = pc;
    if (state == OP_DATA) mem_addr = pc + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= '0;
      instr_valid   <= 1'b0;
      instr_opcode  <= '0;
      instr_operand <= '0;
      instr_pc      <= '0;
    end else if (jump_valid) begin
      pc          <= jump_addr;
      instr_valid <= 1'b0;
      if (state != IDLE || en) state <= OP_ADDR;
    end else begin
      case (state)
        IDLE: begin
          if (en) state <= OP_ADDR;
        end
        OP_ADDR: begin
          state <= OP_DATA;
        end
        OP_DATA: begin
          instr_opcode <= mem_rdata;
          state        <= ARG_DATA;
        end
        ARG_DATA: begin
          instr_operand <= mem_rdata;
          instr_pc      <= pc;
          instr_valid   <= 1'b1;
          state         <= VALID;
        end
        VALID: begin
          if (handshake) begin
            instr_valid <= 1'b0;
            pc          <= pc + ADDR_W'(2);
            state       <= en ? OP_ADDR : IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
